// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe
//   Four-stage pipelined Kyber butterfly over q = 3329. It handles one
//   coefficient pair per en-high cycle, in one of two modes:
//     - mode = 0, Cooley-Tukey (forward NTT):
//           o1 = a + w*b
//           o2 = a - w*b
//     - mode = 1, Gentleman-Sande (inverse NTT):
//           o1 = a + b
//           o2 = (a - b)*w
//   All results are reduced mod q. A swap tag travels with each pair so the
//   downstream 2x2 swap stage receives its select together with the pair it
//   applies to. Latency is fixed at 4 en-high cycles.
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high; takes priority over en
//   en         pipeline advance; 0 freezes every stage and the outputs
//   mode       0 = CT, 1 = GS; sampled per pair
//   valid_in   a/b/w/tag_in carry a pair this cycle
//   a, b, w    12-bit canonical operands (0..q-1)
//   tag_in     swap select carried alongside the pair
//   valid_out  o1/o2/tag_out hold a result
//   o1, o2     12-bit fully reduced results
//   tag_out    tag_in delayed by 4 advances
module ntt_butterfly_pipe (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    input  logic          valid_in,
    input  logic [11:0]   a,
    input  logic [11:0]   b,
    input  logic [11:0]   w,
    input  logic          tag_in,
    output logic          valid_out,
    output logic [11:0]   o1,
    output logic [11:0]   o2,
    output logic          tag_out
);
    localparam int          W         = 12;
    localparam logic [W:0]  Q         = 13'd3329;
    // floor(2^24 / q): the quotient estimate is at most one short, so the
    // remainder always lands in 0..2q-1
    localparam logic [36:0] BARRETT_M = 37'd5039;

    // Stage 1 registers
    logic          s1_valid_q, s1_mode_q, s1_tag_q;
    logic [W-1:0]  s1_a_q, s1_b_q, s1_w_q, s1_sum_q, s1_diff_q;
    // Stage 2 registers
    logic          s2_valid_q, s2_mode_q, s2_tag_q;
    logic [W-1:0]  s2_top_q;
    logic [23:0]   s2_prod_q;
    // Stage 3 registers
    logic          s3_valid_q, s3_mode_q, s3_tag_q;
    logic [W-1:0]  s3_top_q;
    logic [W:0]    s3_rem_q;
    // Stage 4 (output) registers
    logic          valid_q, tag_q;
    logic [W-1:0]  o1_q, o2_q;

    // Next-state values
    logic [W-1:0]  sum_d, diff_d, top_d, o1_d, o2_d;
    logic [23:0]   prod_d;
    logic [W:0]    rem_d;
    logic [W:0]    sum_raw_s, ct_sum_s;
    logic [12:0]   barrett_t_s;
    logic [23:0]   barrett_tq_s;
    logic [W-1:0]  red_s;

    // Stage 1 datapath: modular a+b and a-b (used only by GS pairs)
    always_comb begin
        sum_raw_s = {1'b0, a} + {1'b0, b};
        if (sum_raw_s >= Q) begin
            sum_d = W'(sum_raw_s - Q);
        end else begin
            sum_d = sum_raw_s[W-1:0];
        end
        // Wrap by adding q first so no intermediate goes negative
        if (a >= b) begin
            diff_d = a - b;
        end else begin
            diff_d = W'(({1'b0, a} + Q) - {1'b0, b});
        end
    end

    // Stage 2 datapath: select the multiplicand and the value that bypasses the multiplier
    always_comb begin
        if (s1_mode_q) begin
            prod_d = 24'(s1_w_q) * 24'(s1_diff_q);
            top_d  = s1_sum_q;
        end else begin
            prod_d = 24'(s1_w_q) * 24'(s1_b_q);
            top_d  = s1_a_q;
        end
    end

    // Stage 3 datapath: Barrett reduction of the 24-bit product into 0..2q-1
    always_comb begin
        barrett_t_s  = 13'((37'(s2_prod_q) * BARRETT_M) >> 24);
        barrett_tq_s = 24'(barrett_t_s) * 24'(Q);
        rem_d        = 13'(s2_prod_q - barrett_tq_s);
    end

    // Stage 4 datapath: final conditional subtract, then CT add/sub or GS select
    always_comb begin
        if (s3_rem_q >= Q) begin
            red_s = W'(s3_rem_q - Q);
        end else begin
            red_s = s3_rem_q[W-1:0];
        end
        ct_sum_s = {1'b0, s3_top_q} + {1'b0, red_s};
        if (s3_mode_q) begin
            o1_d = s3_top_q;
            o2_d = red_s;
        end else begin
            if (ct_sum_s >= Q) begin
                o1_d = W'(ct_sum_s - Q);
            end else begin
                o1_d = ct_sum_s[W-1:0];
            end
            if (s3_top_q >= red_s) begin
                o2_d = s3_top_q - red_s;
            end else begin
                o2_d = W'(({1'b0, s3_top_q} + Q) - {1'b0, red_s});
            end
        end
    end

    // Pipeline registers: reset clears everything, en=0 holds every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;  s1_mode_q <= 1'b0;  s1_tag_q <= 1'b0;
            s1_a_q     <= 12'd0; s1_b_q    <= 12'd0; s1_w_q   <= 12'd0;
            s1_sum_q   <= 12'd0; s1_diff_q <= 12'd0;
            s2_valid_q <= 1'b0;  s2_mode_q <= 1'b0;  s2_tag_q <= 1'b0;
            s2_top_q   <= 12'd0; s2_prod_q <= 24'd0;
            s3_valid_q <= 1'b0;  s3_mode_q <= 1'b0;  s3_tag_q <= 1'b0;
            s3_top_q   <= 12'd0; s3_rem_q  <= 13'd0;
            valid_q    <= 1'b0;  tag_q     <= 1'b0;
            o1_q       <= 12'd0; o2_q      <= 12'd0;
        end else if (en) begin
            s1_valid_q <= valid_in; s1_mode_q <= mode;   s1_tag_q <= tag_in;
            s1_a_q     <= a;        s1_b_q    <= b;      s1_w_q   <= w;
            s1_sum_q   <= sum_d;    s1_diff_q <= diff_d;
            s2_valid_q <= s1_valid_q; s2_mode_q <= s1_mode_q; s2_tag_q <= s1_tag_q;
            s2_top_q   <= top_d;      s2_prod_q <= prod_d;
            s3_valid_q <= s2_valid_q; s3_mode_q <= s2_mode_q; s3_tag_q <= s2_tag_q;
            s3_top_q   <= s2_top_q;   s3_rem_q  <= rem_d;
            valid_q    <= s3_valid_q; tag_q     <= s3_tag_q;
            o1_q       <= o1_d;       o2_q      <= o2_d;
        end else begin
            s1_valid_q <= s1_valid_q;
            s2_valid_q <= s2_valid_q;
            s3_valid_q <= s3_valid_q;
            valid_q    <= valid_q;
        end
    end

    assign valid_out = valid_q;
    assign o1        = o1_q;
    assign o2        = o2_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Self-checking bench for ntt_butterfly_pipe: a table of hand-computed
// vectors, streaming with a mid-stream stall, reset with pairs in flight,
// and random traffic checked against a plain modular-arithmetic model
// that tracks the 4-advance latency.
module tb_ntt_butterfly_pipe;
    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        valid_in = 1'b0;
    logic [11:0] a = 12'd0;
    logic [11:0] b = 12'd0;
    logic [11:0] w = 12'd0;
    logic        tag_in = 1'b0;
    logic        valid_out;
    logic [11:0] o1;
    logic [11:0] o2;
    logic        tag_out;

    int checks = 0;
    int errors = 0;

    // Expected pipeline contents; index 3 is what the outputs must show
    bit mv[4];
    int mo1[4];
    int mo2[4];
    bit mt[4];

    typedef struct {
        bit m;
        int av;
        int bv;
        int wv;
        bit t;
        int e1;
        int e2;
    } vec_t;
    vec_t vt[8];

    ntt_butterfly_pipe dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .valid_in(valid_in),
        .a(a), .b(b), .w(w), .tag_in(tag_in),
        .valid_out(valid_out), .o1(o1), .o2(o2), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    function automatic int ref_o1(bit m, int av, int bv, int wv);
        if (m) return (av + bv) % Q;
        return (av + (wv * bv) % Q) % Q;
    endfunction

    function automatic int ref_o2(bit m, int av, int bv, int wv);
        if (m) return (((av - bv + Q) % Q) * wv) % Q;
        return (av - (wv * bv) % Q + Q) % Q;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock cycle: drive, clock, update the model, compare
    task automatic cyc(input bit e, input bit r, input bit v, input bit m,
                       input int av, input int bv, input int wv, input bit t);
        bit p_v, p_t;
        int p1, p2;
        en = e; rst = r; valid_in = v; mode = m; tag_in = t;
        a = 12'(av); b = 12'(bv); w = 12'(wv);
        p_v = valid_out; p_t = tag_out; p1 = int'(o1); p2 = int'(o2);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        end else if (e) begin
            for (int i = 3; i > 0; i--) begin
                mv[i] = mv[i-1]; mo1[i] = mo1[i-1]; mo2[i] = mo2[i-1]; mt[i] = mt[i-1];
            end
            mv[0] = v; mt[0] = t;
            mo1[0] = ref_o1(m, av, bv, wv);
            mo2[0] = ref_o2(m, av, bv, wv);
        end
        #1;
        if (r) begin
            chk("rst_valid", int'(valid_out), 0);
            chk("rst_o1", int'(o1), 0);
            chk("rst_o2", int'(o2), 0);
            chk("rst_tag", int'(tag_out), 0);
        end else begin
            chk("valid_out", int'(valid_out), int'(mv[3]));
            if (mv[3]) begin
                chk("o1", int'(o1), mo1[3]);
                chk("o2", int'(o2), mo2[3]);
                chk("tag_out", int'(tag_out), int'(mt[3]));
            end
            if (!e) begin
                chk("stall_valid", int'(valid_out), int'(p_v));
                chk("stall_o1", int'(o1), p1);
                chk("stall_o2", int'(o2), p2);
                chk("stall_tag", int'(tag_out), int'(p_t));
            end
        end
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        int pairs;
        bit re, rv, rm, rt;

        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0; mo1[i] = 0; mo2[i] = 0; mt[i] = 1'b0;
        end

        // mode, a, b, w, tag, expected o1, expected o2
        vt[0] = '{1'b0, 1,    1,    17,   1'b1, 18,   3313};
        vt[1] = '{1'b1, 5,    3,    17,   1'b0, 8,    34};
        vt[2] = '{1'b1, 3,    5,    17,   1'b1, 8,    3295};
        vt[3] = '{1'b0, 3328, 3328, 3328, 1'b0, 0,    3327};
        vt[4] = '{1'b1, 3328, 3328, 3328, 1'b1, 3327, 0};
        vt[5] = '{1'b0, 0,    1,    1,    1'b0, 1,    3328};
        vt[6] = '{1'b0, 100,  2,    3,    1'b1, 106,  94};
        vt[7] = '{1'b1, 0,    1,    1,    1'b0, 1,    3328};

        // Reset state, including reset while en=0
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Table: one isolated pair each, result exactly 4 advances later
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 1'b1, vt[k].m, vt[k].av, vt[k].bv, vt[k].wv, vt[k].t);
            bubble(3);
            chk($sformatf("vec%0d_valid", k), int'(valid_out), 1);
            chk($sformatf("vec%0d_o1", k), int'(o1), vt[k].e1);
            chk($sformatf("vec%0d_o2", k), int'(o2), vt[k].e2);
            chk($sformatf("vec%0d_tag", k), int'(tag_out), int'(vt[k].t));
            bubble(1);
            chk($sformatf("vec%0d_bubble", k), int'(valid_out), 0);
        end

        // Streaming: 8 back-to-back pairs, alternating mode and tag
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 1'b0, 1'b1, k[0], vt[k].av, vt[k].bv, vt[k].wv, ~k[0]);
        bubble(6);

        // Same stream with en=0 for 3 cycles mid-stream
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                for (int s = 0; s < 3; s++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 7, 7, 7, 1'b1);
            end
            cyc(1'b1, 1'b0, 1'b1, k[0], vt[k].av, vt[k].bv, vt[k].wv, ~k[0]);
        end
        bubble(6);

        // Reset with 3 pairs in flight: nothing stale may emerge afterwards
        for (int k = 0; k < 3; k++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1000 + k, 2, 3, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5, 5, 5, 1'b1);
        bubble(6);

        // Random canonical traffic with en and valid gaps
        pairs = 0;
        while (pairs < 10000) begin
            re = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 3) != 0);
            rm = $urandom_range(0, 1) == 1;
            rt = $urandom_range(0, 1) == 1;
            if (re && rv) pairs++;
            cyc(re, 1'b0, rv, rm, int'($urandom_range(0, Q - 1)),
                int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)), rt);
        end
        bubble(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
